// File: rtl/bus_dev_fifo_port_if.sv
// bus_dev_fifo_port_if: device/arbiter-side signal bundle for bus_dev_fifo_port.
// The master modport is the side that drives strobes and data into the FIFOs
// (device + arbiter), the slave modport is the FIFO port itself.
// Optional build macro: RX_ADDR_FILTER_EN adds the rx_drop_cnt status output.
interface bus_dev_fifo_port_if #(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned deep_fifo = 8
);
    localparam int unsigned CW = $clog2(deep_fifo + 1);

    // device side of the TX FIFO
    logic               tx_wr;
    logic [pckg_sz-1:0] tx_data;
    logic               tx_full;
    logic [CW-1:0]      tx_cnt;
    // arbiter side of the TX FIFO
    logic               pndng;
    logic [pckg_sz-1:0] D_pop;
    logic               pop;
    // arbiter side of the RX FIFO
    logic               push;
    logic [pckg_sz-1:0] D_push;
    // device side of the RX FIFO
    logic               rx_rd;
    logic [pckg_sz-1:0] rx_data;
    logic               rx_empty;
    logic [CW-1:0]      rx_cnt;
    // sticky error reporting
    logic               err_clr;
    logic               tx_ovf;
    logic               rx_ovf;
`ifdef RX_ADDR_FILTER_EN
    logic [7:0]         rx_drop_cnt;
`endif

    modport master (
        output tx_wr, tx_data, pop, push, D_push, rx_rd, err_clr,
        input  tx_full, tx_cnt, pndng, D_pop, rx_data, rx_empty, rx_cnt,
        input  tx_ovf, rx_ovf
`ifdef RX_ADDR_FILTER_EN
        , input rx_drop_cnt
`endif
    );

    modport slave (
        input  tx_wr, tx_data, pop, push, D_push, rx_rd, err_clr,
        output tx_full, tx_cnt, pndng, D_pop, rx_data, rx_empty, rx_cnt,
        output tx_ovf, rx_ovf
`ifdef RX_ADDR_FILTER_EN
        , output rx_drop_cnt
`endif
    );
endinterface

// File: rtl/bus_dev_fifo_port.sv
// bus_dev_fifo_port: per-device endpoint to the bus generator/arbiter.
// TX FIFO is filled by the device and drained by the arbiter (pndng/pop/D_pop);
// RX FIFO is filled by the arbiter (push/D_push) and drained by the device.
// Both FIFOs are first-word-fall-through with fully registered head/status outputs.
// Optional build macro: RX_ADDR_FILTER_EN drops pushes not addressed to id/bcast
// and counts them in rx_drop_cnt.
module bus_dev_fifo_port #(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned deep_fifo = 8,
    parameter logic [7:0]  id        = 8'd0,
    parameter logic [7:0]  bcast     = 8'hFF
) (
    input logic                clk,
    input logic                reset,
    bus_dev_fifo_port_if.slave bus
);
    localparam int unsigned    AW       = $clog2(deep_fifo);
    localparam int unsigned    CW       = $clog2(deep_fifo + 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(deep_fifo);
    localparam logic [CW-1:0]  ONE_CNT  = CW'(1);

    // ---------------- TX FIFO state ----------------
    logic [pckg_sz-1:0] tx_mem_q [deep_fifo];
    logic [AW-1:0]      tx_wr_ptr_q, tx_wr_ptr_d;
    logic [AW-1:0]      tx_rd_ptr_q, tx_rd_ptr_d;
    logic [AW-1:0]      tx_rd_nxt;
    logic [CW-1:0]      tx_cnt_q, tx_cnt_d;
    logic               tx_full_q, tx_full_d;
    logic               pndng_q, pndng_d;
    logic [pckg_sz-1:0] d_pop_q, d_pop_d;
    logic               tx_ovf_q, tx_ovf_d;
    logic               tx_rd_ok, tx_wr_ok, tx_drop;

    // ---------------- RX FIFO state ----------------
    logic [pckg_sz-1:0] rx_mem_q [deep_fifo];
    logic [AW-1:0]      rx_wr_ptr_q, rx_wr_ptr_d;
    logic [AW-1:0]      rx_rd_ptr_q, rx_rd_ptr_d;
    logic [AW-1:0]      rx_rd_nxt;
    logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
    logic               rx_empty_q, rx_empty_d;
    logic [pckg_sz-1:0] rx_data_q, rx_data_d;
    logic               rx_ovf_q, rx_ovf_d;
    logic               rx_rd_ok, rx_wr_ok, rx_drop;
    logic               rx_addr_ok;

    // TX next-state: accept/drop decisions, pointers, count and registered head
    always_comb begin
        tx_rd_ok    = bus.pop && pndng_q;
        tx_wr_ok    = bus.tx_wr && (!tx_full_q || tx_rd_ok);
        tx_drop     = bus.tx_wr && tx_full_q && !tx_rd_ok;
        tx_rd_nxt   = tx_rd_ptr_q + AW'(1);
        tx_wr_ptr_d = tx_wr_ok ? tx_wr_ptr_q + AW'(1) : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ok ? tx_rd_nxt : tx_rd_ptr_q;

        tx_cnt_d = tx_cnt_q;
        if (tx_wr_ok && !tx_rd_ok) begin
            tx_cnt_d = tx_cnt_q + ONE_CNT;
        end else if (!tx_wr_ok && tx_rd_ok) begin
            tx_cnt_d = tx_cnt_q - ONE_CNT;
        end
        tx_full_d = (tx_cnt_d == FULL_CNT);
        pndng_d   = (tx_cnt_d != '0);

        // The head register is loaded from whatever will be at the read pointer
        // after this edge: the incoming word when the FIFO is (about to be) empty
        // except for it, otherwise the stored successor of the popped word.
        if (tx_cnt_d == '0) begin
            d_pop_d = '0;
        end else if (tx_rd_ok) begin
            d_pop_d = (tx_cnt_q == ONE_CNT) ? bus.tx_data : tx_mem_q[tx_rd_nxt];
        end else if (tx_cnt_q == '0) begin
            d_pop_d = bus.tx_data;
        end else begin
            d_pop_d = d_pop_q;
        end

        tx_ovf_d = tx_ovf_q;
        if (bus.err_clr) begin
            tx_ovf_d = 1'b0;
        end
        if (tx_drop) begin
            tx_ovf_d = 1'b1;
        end
    end

    // RX next-state: mirrors TX, with the optional destination filter gating push
    always_comb begin
        rx_rd_ok    = bus.rx_rd && !rx_empty_q;
        rx_wr_ok    = bus.push && rx_addr_ok && ((rx_cnt_q != FULL_CNT) || rx_rd_ok);
        rx_drop     = bus.push && rx_addr_ok && (rx_cnt_q == FULL_CNT) && !rx_rd_ok;
        rx_rd_nxt   = rx_rd_ptr_q + AW'(1);
        rx_wr_ptr_d = rx_wr_ok ? rx_wr_ptr_q + AW'(1) : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ok ? rx_rd_nxt : rx_rd_ptr_q;

        rx_cnt_d = rx_cnt_q;
        if (rx_wr_ok && !rx_rd_ok) begin
            rx_cnt_d = rx_cnt_q + ONE_CNT;
        end else if (!rx_wr_ok && rx_rd_ok) begin
            rx_cnt_d = rx_cnt_q - ONE_CNT;
        end
        rx_empty_d = (rx_cnt_d == '0);

        if (rx_cnt_d == '0) begin
            rx_data_d = '0;
        end else if (rx_rd_ok) begin
            rx_data_d = (rx_cnt_q == ONE_CNT) ? bus.D_push : rx_mem_q[rx_rd_nxt];
        end else if (rx_cnt_q == '0) begin
            rx_data_d = bus.D_push;
        end else begin
            rx_data_d = rx_data_q;
        end

        rx_ovf_d = rx_ovf_q;
        if (bus.err_clr) begin
            rx_ovf_d = 1'b0;
        end
        if (rx_drop) begin
            rx_ovf_d = 1'b1;
        end
    end

`ifdef RX_ADDR_FILTER_EN
    logic [7:0] rx_dest;
    logic [7:0] rx_drop_cnt_q, rx_drop_cnt_d;
    logic [7:0] rx_drop_base;

    // Destination filter and saturating discard counter (err_clr then count, so a
    // discard on the clearing edge leaves the counter at 1)
    always_comb begin
        rx_dest      = bus.D_push[pckg_sz-1 -: 8];
        rx_addr_ok   = (rx_dest == id) || (rx_dest == bcast);
        rx_drop_base = bus.err_clr ? '0 : rx_drop_cnt_q;
        rx_drop_cnt_d = rx_drop_base;
        if (bus.push && !rx_addr_ok && (rx_drop_base != '1)) begin
            rx_drop_cnt_d = rx_drop_base + 8'd1;
        end
    end

    // Discard counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_drop_cnt_q <= '0;
        end else begin
            rx_drop_cnt_q <= rx_drop_cnt_d;
        end
    end

    assign bus.rx_drop_cnt = rx_drop_cnt_q;
`else
    assign rx_addr_ok = 1'b1;
`endif

    // Control/status registers for both FIFOs; reset empties them immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            tx_full_q   <= 1'b0;
            pndng_q     <= 1'b0;
            d_pop_q     <= '0;
            tx_ovf_q    <= 1'b0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            rx_empty_q  <= 1'b1;
            rx_data_q   <= '0;
            rx_ovf_q    <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_full_q   <= tx_full_d;
            pndng_q     <= pndng_d;
            d_pop_q     <= d_pop_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_empty_q  <= rx_empty_d;
            rx_data_q   <= rx_data_d;
            rx_ovf_q    <= rx_ovf_d;
        end
    end

    // Packet storage; not reset, validity is tracked by the pointers/counts
    always_ff @(posedge clk) begin
        if (tx_wr_ok) begin
            tx_mem_q[tx_wr_ptr_q] <= bus.tx_data;
        end
        if (rx_wr_ok) begin
            rx_mem_q[rx_wr_ptr_q] <= bus.D_push;
        end
    end

    assign bus.tx_full  = tx_full_q;
    assign bus.tx_cnt   = tx_cnt_q;
    assign bus.pndng    = pndng_q;
    assign bus.D_pop    = d_pop_q;
    assign bus.tx_ovf   = tx_ovf_q;
    assign bus.rx_empty = rx_empty_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_cnt   = rx_cnt_q;
    assign bus.rx_ovf   = rx_ovf_q;
endmodule

// File: tb/tb_bus_dev_fifo_port.sv
// tb_bus_dev_fifo_port: directed bench for bus_dev_fifo_port (id = 8'h03).
// Writes/pushes that must be accepted enqueue their packet into a scoreboard
// queue; a negedge monitor compares D_pop / rx_data against the queue head
// whenever the arbiter/device consumes a head word.
// Optional build macro: RX_ADDR_FILTER_EN selects the filtered expectations.
module tb_bus_dev_fifo_port;
    localparam int unsigned PW    = 16;
    localparam int unsigned DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bus_dev_fifo_port_if #(.pckg_sz(PW), .deep_fifo(DEPTH)) bus ();

    bus_dev_fifo_port #(
        .pckg_sz  (PW),
        .deep_fifo(DEPTH),
        .id       (8'h03),
        .bcast    (8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [PW-1:0] tx_exp [$];
    logic [PW-1:0] rx_exp [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, pass the edge, return strobes to idle
    task automatic cycle(input logic twr, input logic [PW-1:0] td, input logic pp,
                         input logic psh, input logic [PW-1:0] dp, input logic rrd,
                         input logic ec);
        bus.tx_wr   = twr;
        bus.tx_data = td;
        bus.pop     = pp;
        bus.push    = psh;
        bus.D_push  = dp;
        bus.rx_rd   = rrd;
        bus.err_clr = ec;
        @(posedge clk);
        #1;
        bus.tx_wr   = 1'b0;
        bus.pop     = 1'b0;
        bus.push    = 1'b0;
        bus.rx_rd   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic tx_write(input logic [PW-1:0] d, input bit expect_store);
        if (expect_store) tx_exp.push_back(d);
        cycle(1'b1, d, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic rx_push(input logic [PW-1:0] d, input bit expect_store);
        if (expect_store) rx_exp.push_back(d);
        cycle(1'b0, '0, 1'b0, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic do_pop();
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_rd();
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_clr();
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    // Scoreboard monitor: heads are checked on the consuming cycle, before the edge
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.pop && bus.pndng) begin
                if (tx_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_sb: D_pop=%0h consumed but no packet expected", bus.D_pop);
                end else begin
                    chk("tx_pop_data", 32'(bus.D_pop), 32'(tx_exp.pop_front()));
                end
            end
            if (bus.rx_rd && !bus.rx_empty) begin
                if (rx_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_sb: rx_data=%0h consumed but no packet expected", bus.rx_data);
                end else begin
                    chk("rx_rd_data", 32'(bus.rx_data), 32'(rx_exp.pop_front()));
                end
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_pndng"},    32'(bus.pndng),    0);
        chk({tag, "_D_pop"},    32'(bus.D_pop),    0);
        chk({tag, "_tx_full"},  32'(bus.tx_full),  0);
        chk({tag, "_tx_cnt"},   32'(bus.tx_cnt),   0);
        chk({tag, "_rx_empty"}, 32'(bus.rx_empty), 1);
        chk({tag, "_rx_data"},  32'(bus.rx_data),  0);
        chk({tag, "_rx_cnt"},   32'(bus.rx_cnt),   0);
        chk({tag, "_tx_ovf"},   32'(bus.tx_ovf),   0);
        chk({tag, "_rx_ovf"},   32'(bus.rx_ovf),   0);
`ifdef RX_ADDR_FILTER_EN
        chk({tag, "_drop_cnt"}, 32'(bus.rx_drop_cnt), 0);
`endif
    endtask

    initial begin
        bus.tx_wr = 1'b0; bus.tx_data = '0; bus.pop = 1'b0; bus.push = 1'b0;
        bus.D_push = '0; bus.rx_rd = 1'b0; bus.err_clr = 1'b0;

        // reset state
        #12;
        chk_idle("rst");
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;

        // T2: TX FWFT
        tx_write(16'h0312, 1'b1);
        chk("t2_pndng", 32'(bus.pndng), 1);
        chk("t2_dpop1", 32'(bus.D_pop), 32'h0312);
        chk("t2_cnt1",  32'(bus.tx_cnt), 1);
        tx_write(16'h0455, 1'b1);
        chk("t2_cnt2",  32'(bus.tx_cnt), 2);
        do_pop();
        chk("t2_dpop2", 32'(bus.D_pop), 32'h0455);
        do_pop();
        chk("t2_pndng0", 32'(bus.pndng), 0);
        chk("t2_dpop0",  32'(bus.D_pop), 0);
        do_pop();                                   // pop while empty is ignored
        chk("t2_cnt_nounder", 32'(bus.tx_cnt), 0);
        tx_exp.push_back(16'h0777);                 // write+pop on empty: write only
        cycle(1'b1, 16'h0777, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t2_wrpop_empty_cnt",  32'(bus.tx_cnt), 1);
        chk("t2_wrpop_empty_head", 32'(bus.D_pop), 32'h0777);
        do_pop();

        // T3: TX full / overflow
        for (int i = 0; i < 8; i++) tx_write(PW'(16'h1000 + i), 1'b1);
        chk("t3_full",    32'(bus.tx_full), 1);
        chk("t3_cnt8",    32'(bus.tx_cnt), 8);
        chk("t3_ovf_pre", 32'(bus.tx_ovf), 0);
        tx_write(16'hBEEF, 1'b0);
        chk("t3_ovf",     32'(bus.tx_ovf), 1);
        chk("t3_cnt_drop", 32'(bus.tx_cnt), 8);
        tx_exp.push_back(16'hCAFE);
        cycle(1'b1, 16'hCAFE, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("t3_cnt_wrpop", 32'(bus.tx_cnt), 8);
        chk("t3_head_wrpop", 32'(bus.D_pop), 32'h1001);
        do_clr();
        chk("t3_ovf_clr", 32'(bus.tx_ovf), 0);
        for (int i = 0; i < 8; i++) do_pop();
        chk("t3_drained", 32'(bus.pndng), 0);
        chk("t3_notfull", 32'(bus.tx_full), 0);

        // T4: pointer wrap with overlapping write+pop
        tx_write(16'd0, 1'b1);
        for (int i = 1; i < 20; i++) begin
            tx_exp.push_back(PW'(i));
            cycle(1'b1, PW'(i), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        end
        do_pop();
        chk("t4_cnt0", 32'(bus.tx_cnt), 0);

        // T5: RX full / overflow
        rx_push(16'h0300, 1'b1);
        chk("t5_rx_nempty", 32'(bus.rx_empty), 0);
        chk("t5_rx_head",   32'(bus.rx_data), 32'h0300);
        for (int i = 1; i < 8; i++) rx_push(PW'(16'h0300 + i), 1'b1);
        chk("t5_rx_cnt8", 32'(bus.rx_cnt), 8);
        rx_push(16'h03EE, 1'b0);
        chk("t5_rx_ovf",  32'(bus.rx_ovf), 1);
        chk("t5_rx_cnt_drop", 32'(bus.rx_cnt), 8);
        do_clr();
        chk("t5_rx_ovf_clr1", 32'(bus.rx_ovf), 0);
        cycle(1'b0, '0, 1'b0, 1'b1, 16'h03EF, 1'b0, 1'b1);   // drop and clear together
        chk("t5_set_wins", 32'(bus.rx_ovf), 1);
        rx_exp.push_back(16'h03AA);
        cycle(1'b0, '0, 1'b0, 1'b1, 16'h03AA, 1'b1, 1'b0);
        chk("t5_cnt_pushrd", 32'(bus.rx_cnt), 8);
        chk("t5_head_pushrd", 32'(bus.rx_data), 32'h0301);
        do_clr();
        chk("t5_rx_ovf_clr2", 32'(bus.rx_ovf), 0);
        for (int i = 0; i < 8; i++) do_rd();
        chk("t5_rx_empty", 32'(bus.rx_empty), 1);
        chk("t5_rx_data0", 32'(bus.rx_data), 0);
        do_rd();                                    // read while empty is ignored
        chk("t5_rx_nounder", 32'(bus.rx_cnt), 0);

        // T6: destination filter
`ifdef RX_ADDR_FILTER_EN
        rx_push(16'h0301, 1'b1);
        rx_push(16'h0702, 1'b0);
        rx_push(16'hFF03, 1'b1);
        chk("t6_rx_cnt",   32'(bus.rx_cnt), 2);
        chk("t6_drop_cnt", 32'(bus.rx_drop_cnt), 1);
        chk("t6_no_ovf",   32'(bus.rx_ovf), 0);
        do_clr();
        chk("t6_drop_clr", 32'(bus.rx_drop_cnt), 0);
        do_rd(); do_rd();
`else
        rx_push(16'h0301, 1'b1);
        rx_push(16'h0702, 1'b1);
        rx_push(16'hFF03, 1'b1);
        chk("t6_rx_cnt", 32'(bus.rx_cnt), 3);
        do_rd(); do_rd(); do_rd();
`endif
        chk("t6_empty", 32'(bus.rx_empty), 1);

        // T1: asynchronous reset in the middle of traffic
        for (int i = 0; i < 8; i++) tx_write(PW'(16'h2000 + i), 1'b0);
        tx_write(16'h2FFF, 1'b0);
        rx_push(16'h0311, 1'b0);
        rx_push(16'h0322, 1'b0);
        chk("t1_pre_ovf", 32'(bus.tx_ovf), 1);
        chk("t1_pre_cnt", 32'(bus.tx_cnt), 8);
        #2 reset = 1'b1;
        #1;
        chk_idle("t1");
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        tx_write(16'h0ABC, 1'b1);
        chk("t1_after_head", 32'(bus.D_pop), 32'h0ABC);
        do_pop();

        chk("tx_sb_left", 32'(tx_exp.size()), 0);
        chk("rx_sb_left", 32'(rx_exp.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
